// File: rtl/md5_match.sv
// md5_match: watches the md5core output stream and compares each 128-bit digest
// against a host-loaded target. The first match captures the candidate message
// and halts the search. Valid digests seen during a search are counted.
module md5_match #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [7:0]         tgt_byte,
    input  logic               tgt_wr,
    input  logic               arm,
    input  logic               clear,
    input  logic [31:0]        a_in,
    input  logic [31:0]        b_in,
    input  logic [31:0]        c_in,
    input  logic [31:0]        d_in,
    input  logic [151:0]       m_in,
    input  logic               valid_in,
    output logic               tgt_loaded,
    output logic               busy,
    output logic               match,
    output logic [151:0]       match_msg,
    output logic [COUNT_W-1:0] hash_count
);

    typedef enum logic [1:0] {
        IDLE,
        READY,
        SEARCH,
        FOUND
    } state_t;

    state_t state;
    state_t state_next;

    logic [127:0] target;
    logic [3:0]   byte_cnt;

    logic [3:0]   s1_eq;
    logic [151:0] s1_m;
    logic         s1_valid;

    logic         load_take;
    logic         arm_take;
    logic         stage2_act;
    logic         stage2_hit;

    // Command qualification: clear outranks arm, arm outranks target writes,
    // and clear suppresses the stage-2 decision in the same cycle.
    always_comb begin
        load_take  = 1'b0;
        arm_take   = 1'b0;
        stage2_act = 1'b0;
        stage2_hit = 1'b0;
        if (!clear) begin
            load_take  = tgt_wr && (state == IDLE);
            arm_take   = arm && (state == READY);
            stage2_act = en && s1_valid && (state == SEARCH);
            stage2_hit = stage2_act && (&s1_eq);
        end
    end

    // Next-state logic for the search controller.
    always_comb begin
        state_next = state;
        if (clear) begin
            case (state)
                READY:   state_next = IDLE;
                SEARCH:  state_next = READY;
                FOUND:   state_next = READY;
                default: state_next = state;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (load_take && (byte_cnt == 4'd15)) begin
                        state_next = READY;
                    end
                end
                READY: begin
                    if (arm_take) begin
                        state_next = SEARCH;
                    end
                end
                SEARCH: begin
                    if (stage2_hit) begin
                        state_next = FOUND;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Target shift register, byte counter and load-complete flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            target     <= '0;
            byte_cnt   <= '0;
            tgt_loaded <= 1'b0;
        end else if (clear && (state == READY)) begin
            target     <= '0;
            byte_cnt   <= '0;
            tgt_loaded <= 1'b0;
        end else if (load_take) begin
            target   <= {target[119:0], tgt_byte};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
                tgt_loaded <= 1'b1;
            end
        end
    end

    // Stage 1: per-word equality and message capture; emptied when a search starts
    // so beats that arrived before arm can never be counted or matched.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_eq    <= '0;
            s1_m     <= '0;
            s1_valid <= 1'b0;
        end else if (arm_take) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_eq    <= {a_in == target[127:96],
                         b_in == target[95:64],
                         c_in == target[63:32],
                         d_in == target[31:0]};
            s1_m     <= m_in;
            s1_valid <= valid_in;
        end
    end

    // Stage 2: saturating hash counter and first-match message capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            hash_count <= '0;
            match_msg  <= '0;
        end else if (arm_take) begin
            hash_count <= '0;
            match_msg  <= '0;
        end else if (stage2_act) begin
            if (hash_count != '1) begin
                hash_count <= hash_count + COUNT_W'(1);
            end
            if (stage2_hit) begin
                match_msg <= s1_m;
            end
        end
    end

    assign busy  = (state == SEARCH);
    assign match = (state == FOUND);

endmodule

// File: doc/md5_match.md
Name: md5_match

Overview:
- Consumer end of the md5core output stream: takes per-cycle {a_out,b_out,c_out,d_out,m_out,valid_out} and compares each 128-bit digest against a host-loaded target.
- On the first match, captures the 19-char (152-bit) candidate message and halts the search.
- Counts the hashes examined.
- Sits between md5core and the host/UART command logic.

Parameters:
COUNT_W, 32, width of hash_count; saturating.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
en  in  1  pipeline enable; same signal that drives md5core en
tgt_byte  in  8  target digest byte, MSB-first (first byte -> target[127:120])
tgt_wr  in  1  strobe; writes tgt_byte for one cycle
arm  in  1  pulse; start search
clear  in  1  pulse; abort/acknowledge
a_in  in  32  md5core a_out (already byte-swapped)
b_in  in  32  md5core b_out
c_in  in  32  md5core c_out
d_in  in  32  md5core d_out
m_in  in  152  md5core m_out
valid_in  in  1  md5core valid_out
tgt_loaded  out  1  all 16 target bytes written
busy  out  1  state == SEARCH
match  out  1  match found (sticky)
match_msg  out  152  captured message of first match
hash_count  out  COUNT_W  valid digests examined in current search

Behaviour:
- Clock and reset: clk; reset synchronous, active-high. Reset overrides all inputs.
- Reset values: state=IDLE; byte_cnt=0; target=0; all outputs 0; pipeline stage valid=0.
- Digest ordering: digest = {a_in,b_in,c_in,d_in}; 127:96=a_in, 31:0=d_in.
- Target load:
  - In IDLE only: each tgt_wr shifts target <= {target[119:0], tgt_byte} and byte_cnt++.
  - On the 16th write: tgt_loaded=1 the next cycle; state -> READY.
  - tgt_wr in any other state is ignored.
- Compare pipeline (2 stages; advances only when en=1):
  - Stage 1 registers eq[3:0] (per-word equality a/b/c/d vs target), m_in, and valid_in.
  - Stage 2, in SEARCH with s1_valid: hash_count++, saturating at all-ones.
  - If &eq as well: match_msg <= s1_m, match <= 1, state -> FOUND.
  - Latency: match rises 2 en-cycles after the matching valid_in beat.
  - en=0 freezes stage 1, hash_count, and state transitions on data. arm/clear/tgt_wr still act.
- State machine (IDLE, READY, SEARCH, FOUND):
  - IDLE -> READY: 16th tgt_wr.
  - READY -> SEARCH: arm. On entry: hash_count=0, match_msg=0, stage 1 flushed (s1_valid=0).
  - SEARCH -> FOUND: stage-2 match.
  - SEARCH -> READY: clear (abort). hash_count is held for readback.
  - FOUND -> READY: clear. match=0; match_msg and hash_count held until next arm.
  - READY -> IDLE: clear. byte_cnt=0, tgt_loaded=0, target=0.
  - arm in IDLE/SEARCH/FOUND is ignored.
- Priority: reset > clear > arm > tgt_wr > data match.
  - clear and a stage-2 match in the same cycle: clear wins; no capture; match stays 0.
- First match only: in FOUND, further valid beats are ignored; hash_count is frozen.
- Stage 1 keeps loading outside SEARCH, but stage 2 acts only in SEARCH. Beats already in stage 1 at arm are discarded by the flush.

Test Plan:
- Load/match: load target 0x0123456789abcdeffedcba9876543210, arm, then drive 3 non-matching valid beats plus a matching beat (a=0x01234567, b=0x89abcdef, c=0xfedcba98, d=0x76543210, m=152'h41..41) -> match=1 two cycles after the matching beat; match_msg=41..41; hash_count=4; busy=0.
- Near-miss: d_in=0x76543211 with a/b/c correct -> no match; hash_count increments; busy stays 1.
- en stall: matching beat presented, then en=0 for 5 cycles -> match stays 0; it rises 2 cycles after en returns to 1.
- Load boundary: 15 tgt_wr then arm -> ignored (busy=0, tgt_loaded=0); 16th write -> tgt_loaded=1; tgt_wr during SEARCH leaves the target unchanged.
- Simultaneous clear + match: clear asserted in the same cycle the matching beat reaches stage 2 -> match=0, state READY; re-arm with no beats -> hash_count=0.
- Saturation and reset: COUNT_W=4, 20 non-matching beats -> hash_count=15. Reset mid-SEARCH -> all outputs 0 next cycle; tgt_loaded=0.
